// File: rtl/cocomem_pkg.sv
// Shared definitions for the CoCo memory-window initiator: op codes, FSM states,
// MMU window register addresses and the idle bus address.
package cocomem_pkg;

  typedef enum logic [1:0] {
    OP_REG_WR   = 2'b00,
    OP_REG_RD   = 2'b01,
    OP_MEM_FILL = 2'b10,
    OP_MEM_DUMP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE, REG, SET_LO, SET_MID, SET_HI, XFER, RSP, DONE
  } state_e;

  localparam int unsigned ADDR_W = 21;

  localparam logic [15:0] WIN_LO    = 16'hFD00;
  localparam logic [15:0] WIN_MID   = 16'hFD01;
  localparam logic [15:0] WIN_HI    = 16'hFD02;
  localparam logic [15:0] WIN_DATA  = 16'hFD03;
  localparam logic [15:0] ADDR_IDLE = 16'hFFFF;

endpackage

// File: rtl/mmu_addr_ctr.sv
// 21-bit physical address and remaining-byte counter for MEM ops, with carry flags
// that tell the initiator which window bytes must be rewritten.
module mmu_addr_ctr
  import cocomem_pkg::*;
(
  input  logic              e,
  input  logic              _reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              carry7,
  output logic              carry15
);

  logic [8:0]        remaining;
  logic [ADDR_W-1:0] addr_nxt;

  assign addr_nxt = addr + 21'd1;
  assign last     = (remaining == 9'd1);

  // Load sets both carries so the first window setup always writes all three bytes.
  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      addr      <= '0;
      remaining <= '0;
      carry7    <= 1'b0;
      carry15   <= 1'b0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= (load_len == 8'd0) ? 9'd256 : {1'b0, load_len};
      carry7    <= 1'b1;
      carry15   <= 1'b1;
    end else if (step) begin
      addr      <= addr_nxt;
      remaining <= remaining - 9'd1;
      carry7    <= (addr_nxt[7:0] == 8'd0);
      carry15   <= (addr_nxt[15:0] == 16'd0);
    end
  end

endmodule

// File: rtl/mmu_initiator.sv
// Command-driven MMU bus initiator: register read/write and windowed memory fill/dump.
// MEM_DUMP bus support is built only when MMU_INITIATOR_DUMP_EN is defined.
module mmu_initiator
  import cocomem_pkg::*;
(
  input  logic              e,
  input  logic              _reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              done,
  output logic [15:0]       address_cpu,
  output logic [7:0]        data_out,
  input  logic [7:0]        data_in,
  output logic              r_w_cpu
);

  state_e            state, state_nxt;
  op_e               op_q;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] addr;
  logic              accept, step, last, carry7, carry15;

  assign accept = cmd_valid && (state == IDLE);

  mmu_addr_ctr u_addr_ctr (
    .e         (e),
    ._reset    (_reset),
    .load      (accept),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .step      (step),
    .addr      (addr),
    .last      (last),
    .carry7    (carry7),
    .carry15   (carry15)
  );

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      op_q     <= OP_REG_WR;
      data_q   <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
      end
      if ((state == REG && op_q == OP_REG_RD) || (state == XFER && op_q == OP_MEM_DUMP))
        rsp_data <= data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_REG_WR, OP_REG_RD: state_nxt = REG;
            OP_MEM_FILL:          state_nxt = SET_LO;
`ifdef MMU_INITIATOR_DUMP_EN
            default:              state_nxt = SET_LO;
`else
            default:              state_nxt = DONE;
`endif
          endcase
        end
      end
      REG:     state_nxt = (op_q == OP_REG_RD) ? RSP : DONE;
      SET_LO:  state_nxt = carry7 ? SET_MID : XFER;
      SET_MID: state_nxt = carry15 ? SET_HI : XFER;
      SET_HI:  state_nxt = XFER;
      XFER: begin
        if (op_q == OP_MEM_DUMP) state_nxt = RSP;
        else if (last)           state_nxt = DONE;
        else begin
          step      = 1'b1;
          state_nxt = SET_LO;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          if (op_q == OP_MEM_DUMP && !last) begin
            step      = 1'b1;
            state_nxt = SET_LO;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state == IDLE);
    rsp_valid   = (state == RSP);
    done        = (state == DONE);
    address_cpu = ADDR_IDLE;
    r_w_cpu     = 1'b1;
    data_out    = '0;
    case (state)
      REG: begin
        address_cpu = addr[15:0];
        r_w_cpu     = (op_q == OP_REG_RD);
        if (op_q == OP_REG_WR) data_out = data_q;
      end
      SET_LO: begin
        address_cpu = WIN_LO;
        r_w_cpu     = 1'b0;
        data_out    = addr[7:0];
      end
      SET_MID: begin
        address_cpu = WIN_MID;
        r_w_cpu     = 1'b0;
        data_out    = addr[15:8];
      end
      SET_HI: begin
        address_cpu = WIN_HI;
        r_w_cpu     = 1'b0;
        data_out    = {3'b000, addr[20:16]};
      end
      XFER: begin
        address_cpu = WIN_DATA;
        r_w_cpu     = (op_q == OP_MEM_DUMP);
        if (op_q == OP_MEM_FILL) data_out = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmu_initiator.sv
// Randomized self-checking bench for mmu_initiator against a transaction-level model.
module tb_mmu_initiator;

  typedef struct packed {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
  } bus_t;

`ifdef MMU_INITIATOR_DUMP_EN
  localparam bit DUMP_EN = 1'b1;
`else
  localparam bit DUMP_EN = 1'b0;
`endif

  logic        e, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [20:0] cmd_addr;
  logic [7:0]  cmd_len, cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_data;
  logic        done;
  logic [15:0] address_cpu;
  logic [7:0]  data_out, data_in;
  logic        r_w_cpu;

  int unsigned vectors = 0, miscompares = 0;

  bus_t       bus_q[$], exp_bus[$];
  logic [7:0] rsp_q[$], exp_rsp[$];
  int unsigned done_cnt, done_at, rv_cycles, unstable, busy_ready;
  bit timed_out;
  logic ready_after, done_after;

  mmu_initiator dut (
    .e(e), ._reset(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .address_cpu(address_cpu), .data_out(data_out), .data_in(data_in),
    .r_w_cpu(r_w_cpu)
  );

  initial begin
    e = 1'b0;
    forever #5 e = ~e;
  end

  // Reference model: the expected list of bus cycles for one command.
  task automatic model(input logic [1:0] op, input logic [20:0] addr, input logic [7:0] len,
                       input logic [7:0] data);
    logic [20:0] a;
    int n;
    a = addr;
    n = (len == 8'd0) ? 256 : int'(len);
    exp_bus.delete();
    if (op == 2'b00) exp_bus.push_back(bus_t'({addr[15:0], 1'b0, data}));
    else if (op == 2'b01) exp_bus.push_back(bus_t'({addr[15:0], 1'b1, 8'h00}));
    else if (op == 2'b10 || DUMP_EN) begin
      exp_bus.push_back(bus_t'({16'hFD00, 1'b0, a[7:0]}));
      exp_bus.push_back(bus_t'({16'hFD01, 1'b0, a[15:8]}));
      exp_bus.push_back(bus_t'({16'hFD02, 1'b0, 3'b000, a[20:16]}));
      for (int i = 0; i < n; i++) begin
        if (op == 2'b10) exp_bus.push_back(bus_t'({16'hFD03, 1'b0, data}));
        else             exp_bus.push_back(bus_t'({16'hFD03, 1'b1, 8'h00}));
        if (i != n - 1) begin
          a = a + 21'd1;
          exp_bus.push_back(bus_t'({16'hFD00, 1'b0, a[7:0]}));
          if (a[7:0] == 8'd0)  exp_bus.push_back(bus_t'({16'hFD01, 1'b0, a[15:8]}));
          if (a[15:0] == 16'd0) exp_bus.push_back(bus_t'({16'hFD02, 1'b0, 3'b000, a[20:16]}));
        end
      end
    end
  endtask

  // Issue one command and observe the bus/response streams until done or budget expiry.
  task automatic exec(input logic [1:0] op, input logic [20:0] addr, input logic [7:0] len,
                      input logic [7:0] data, input int unsigned ready_pct,
                      input int unsigned hold_low, input int rd_val, input int unsigned budget);
    int unsigned cyc, wait_cyc;
    bus_t b;
    logic [7:0] prev_data;
    bit prev_pending;
    bus_q.delete(); rsp_q.delete(); exp_rsp.delete();
    done_cnt = 0; done_at = 0; rv_cycles = 0; unstable = 0; busy_ready = 0; timed_out = 0;
    prev_pending = 0; prev_data = '0;
    wait_cyc = 0;
    while (cmd_ready !== 1'b1 && wait_cyc < 20) begin
      @(negedge e);
      wait_cyc++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
    @(negedge e);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 21'($urandom);
    cmd_len = 8'($urandom); cmd_data = 8'($urandom);
    cyc = 1;
    while (1) begin
      if (cyc > budget) begin
        timed_out = 1;
        break;
      end
      if (!(address_cpu === 16'hFFFF && r_w_cpu === 1'b1 && data_out === 8'h00)) begin
        b.a = address_cpu; b.rw = r_w_cpu; b.d = (r_w_cpu === 1'b1) ? 8'h00 : data_out;
        bus_q.push_back(b);
      end
      if (r_w_cpu === 1'b1 && address_cpu !== 16'hFFFF) begin
        data_in = (rd_val >= 0) ? rd_val[7:0] : 8'($urandom);
        exp_rsp.push_back(data_in);
      end else begin
        data_in = 8'($urandom);
      end
      if (cmd_ready !== 1'b0) busy_ready++;
      if (rsp_valid === 1'b1) begin
        if (prev_pending && rsp_data !== prev_data) unstable++;
        rsp_ready = (rv_cycles < hold_low) ? 1'b0 : ($urandom_range(99) < ready_pct);
        rv_cycles++;
        if (rsp_ready) begin
          rsp_q.push_back(rsp_data);
          prev_pending = 0;
        end else begin
          prev_pending = 1;
          prev_data = rsp_data;
        end
      end else begin
        if (prev_pending) unstable++;
        prev_pending = 0;
        rsp_ready = 1'($urandom_range(1));
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
        break;
      end
      @(negedge e);
      cyc++;
    end
    rsp_ready = 1'b0;
    @(negedge e);
    ready_after = cmd_ready;
    done_after = done;
  endtask

  function automatic int bus_diff();
    int n;
    n = (bus_q.size() < exp_bus.size()) ? bus_q.size() : exp_bus.size();
    for (int i = 0; i < n; i++) if (bus_q[i] !== exp_bus[i]) return i;
    if (bus_q.size() != exp_bus.size()) return n;
    return -1;
  endfunction

  function automatic int rsp_diff();
    int n;
    n = (rsp_q.size() < exp_rsp.size()) ? rsp_q.size() : exp_rsp.size();
    for (int i = 0; i < n; i++) if (rsp_q[i] !== exp_rsp[i]) return i;
    if (rsp_q.size() != exp_rsp.size()) return n;
    return -1;
  endfunction

  task automatic report_bus(input string name, input int idx);
    bus_t g, x;
    g = '1; x = '1;
    if (idx < bus_q.size()) g = bus_q[idx];
    if (idx < exp_bus.size()) x = exp_bus[idx];
    $display("FAIL %s: bus[%0d] got %h exp %h (count got %0d exp %0d)", name, idx, g, x,
             bus_q.size(), exp_bus.size());
  endtask

  task automatic test_reset();
    @(negedge e); @(negedge e);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b exp 0", done); end
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL rst_rsp_data: got %h exp 00", rsp_data); end
    vectors++; if (address_cpu !== 16'hFFFF) begin miscompares++; $display("FAIL rst_addr: got %h exp FFFF", address_cpu); end
    vectors++; if (r_w_cpu !== 1'b1) begin miscompares++; $display("FAIL rst_rw: got %b exp 1", r_w_cpu); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL rst_data_out: got %h exp 00", data_out); end
    rst_n = 1'b1;
    @(negedge e);
  endtask

  task automatic test_reg_wr();
    int idx;
    model(2'b00, 21'h00FF90, 8'd0, 8'h40);
    exec(2'b00, 21'h00FF90, 8'd0, 8'h40, 100, 0, -1, 50);
    idx = bus_diff();
    vectors++; if (idx !== -1) begin miscompares++; report_bus("reg_wr_bus", idx); end
    vectors++; if (done_at !== 2) begin miscompares++; $display("FAIL reg_wr_done_at: got %0d exp 2", done_at); end
    vectors++; if (ready_after !== 1'b1) begin miscompares++; $display("FAIL reg_wr_ready_k3: got %b exp 1", ready_after); end
    vectors++; if (done_after !== 1'b0) begin miscompares++; $display("FAIL reg_wr_done_pulse: got %b exp 0", done_after); end
    vectors++; if (busy_ready !== 0) begin miscompares++; $display("FAIL reg_wr_busy_ready: got %0d exp 0", busy_ready); end
    for (int i = 0; i < 4; i++) begin
      logic [20:0] a;
      logic [7:0] d;
      a = 21'($urandom); d = 8'($urandom);
      model(2'b00, a, 8'd0, d);
      exec(2'b00, a, 8'($urandom), d, 100, 0, -1, 50);
      idx = bus_diff();
      vectors++; if (idx !== -1) begin miscompares++; report_bus("reg_wr_rand_bus", idx); end
      vectors++; if (done_at !== 2) begin miscompares++; $display("FAIL reg_wr_rand_done_at: got %0d exp 2", done_at); end
    end
  endtask

  task automatic test_reg_rd();
    int idx;
    model(2'b01, 21'h00FFA3, 8'd0, 8'h00);
    exec(2'b01, 21'h00FFA3, 8'd0, 8'h00, 100, 5, 'h3A, 50);
    idx = bus_diff();
    vectors++; if (idx !== -1) begin miscompares++; report_bus("reg_rd_bus", idx); end
    vectors++; if (rsp_q.size() !== 1) begin miscompares++; $display("FAIL reg_rd_rsp_count: got %0d exp 1", rsp_q.size()); end
    else begin
      vectors++; if (rsp_q[0] !== 8'h3A) begin miscompares++; $display("FAIL reg_rd_rsp_data: got %h exp 3A", rsp_q[0]); end
    end
    vectors++; if (rv_cycles !== 6) begin miscompares++; $display("FAIL reg_rd_valid_cycles: got %0d exp 6", rv_cycles); end
    vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL reg_rd_stable: got %0d exp 0", unstable); end
    vectors++; if (done_at !== 8) begin miscompares++; $display("FAIL reg_rd_done_at: got %0d exp 8", done_at); end
    for (int i = 0; i < 4; i++) begin
      logic [20:0] a;
      a = 21'($urandom);
      model(2'b01, a, 8'd0, 8'h00);
      exec(2'b01, a, 8'd0, 8'($urandom), 50, 0, -1, 200);
      idx = rsp_diff();
      vectors++; if (idx !== -1 || bus_diff() !== -1) begin
        miscompares++; $display("FAIL reg_rd_rand: rsp diff at %0d, bus diff at %0d, exp none", idx, bus_diff());
      end
    end
  endtask

  task automatic test_mem_fill();
    int idx;
    model(2'b10, 21'h0120FE, 8'd3, 8'h55);
    exec(2'b10, 21'h0120FE, 8'd3, 8'h55, 100, 0, -1, 100);
    idx = bus_diff();
    vectors++; if (idx !== -1) begin miscompares++; report_bus("fill_example_bus", idx); end
    vectors++; if (bus_q.size() !== 9) begin miscompares++; $display("FAIL fill_example_count: got %0d exp 9", bus_q.size()); end
    vectors++; if (done_at !== 10) begin miscompares++; $display("FAIL fill_example_done_at: got %0d exp 10", done_at); end
    model(2'b10, 21'h000010, 8'd5, 8'hA7);
    exec(2'b10, 21'h000010, 8'd5, 8'hA7, 100, 0, -1, 100);
    vectors++; if (bus_q.size() !== 12) begin miscompares++; $display("FAIL fill_nocarry_cycles: got %0d exp 12", bus_q.size()); end
    for (int i = 0; i < 5; i++) begin
      logic [20:0] a;
      logic [7:0] l, d;
      a = {13'($urandom), 8'($urandom_range(255, 240))};
      l = 8'($urandom_range(40, 1));
      d = 8'($urandom);
      model(2'b10, a, l, d);
      exec(2'b10, a, l, d, 100, 0, -1, 400);
      idx = bus_diff();
      vectors++; if (idx !== -1) begin miscompares++; report_bus("fill_rand_bus", idx); end
      vectors++; if (done_at !== exp_bus.size() + 1) begin
        miscompares++; $display("FAIL fill_rand_done_at: got %0d exp %0d", done_at, exp_bus.size() + 1);
      end
    end
  endtask

  task automatic test_fill_wrap();
    int idx;
    model(2'b10, 21'h1FFFFF, 8'd2, 8'hC3);
    exec(2'b10, 21'h1FFFFF, 8'd2, 8'hC3, 100, 0, -1, 100);
    idx = bus_diff();
    vectors++; if (idx !== -1) begin miscompares++; report_bus("fill_wrap_bus", idx); end
    vectors++; if (done_cnt !== 1 || timed_out) begin
      miscompares++; $display("FAIL fill_wrap_done: got %0d pulses timeout %0d exp 1 pulse", done_cnt, timed_out);
    end
  endtask

  task automatic test_dump();
    int idx;
    logic [20:0] a;
    a = 21'($urandom);
    model(2'b11, a, 8'd0, 8'h00);
    exec(2'b11, a, 8'd0, 8'h00, 50, 0, -1, 6000);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL dump_timeout: got timeout exp done"); end
    idx = bus_diff();
    vectors++; if (idx !== -1) begin miscompares++; report_bus("dump_bus", idx); end
    if (DUMP_EN) begin
      vectors++; if (rsp_q.size() !== 256) begin miscompares++; $display("FAIL dump_rsp_count: got %0d exp 256", rsp_q.size()); end
      idx = rsp_diff();
      vectors++; if (idx !== -1) begin miscompares++; $display("FAIL dump_rsp_order: first diff at %0d exp none", idx); end
      vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL dump_stable: got %0d exp 0", unstable); end
    end else begin
      vectors++; if (rv_cycles !== 0) begin miscompares++; $display("FAIL dump_off_rsp: got %0d exp 0", rv_cycles); end
      vectors++; if (done_at !== 1) begin miscompares++; $display("FAIL dump_off_done_at: got %0d exp 1", done_at); end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned n, bad, done_seen;
    while (cmd_ready !== 1'b1) @(negedge e);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 21'($urandom); cmd_len = 8'd4; cmd_data = 8'h99;
    @(negedge e);
    cmd_valid = 1'b0;
    n = 0;
    while (address_cpu !== 16'hFD01 && n < 10) begin @(negedge e); n++; end
    vectors++; if (address_cpu !== 16'hFD01) begin miscompares++; $display("FAIL rmid_reach_set_mid: got %h exp FD01", address_cpu); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if ({address_cpu, r_w_cpu, data_out} !== {16'hFFFF, 1'b1, 8'h00}) begin
      miscompares++; $display("FAIL rmid_bus_idle: got %h/%b/%h exp FFFF/1/00", address_cpu, r_w_cpu, data_out);
    end
    @(negedge e);
    rst_n = 1'b1;
    bad = 0; done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge e);
      if (done === 1'b1) done_seen++;
      if (address_cpu !== 16'hFFFF || r_w_cpu !== 1'b1 || data_out !== 8'h00 || cmd_ready !== 1'b1) bad++;
    end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL rmid_no_done: got %0d exp 0", done_seen); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rmid_idle_ready: got %0d bad cycles exp 0", bad); end
    // Reset while a response is pending drops it.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 21'h00FF12;
    @(negedge e);
    cmd_valid = 1'b0; data_in = 8'hC5;
    @(negedge e);
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hC5) begin
      miscompares++; $display("FAIL rrsp_pending: got %b/%h exp 1/C5", rsp_valid, rsp_data);
    end
    rst_n = 1'b0;
    #1;
    vectors++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL rrsp_dropped: got %b/%h/%b exp 0/00/1", rsp_valid, rsp_data, cmd_ready);
    end
    @(negedge e);
    rst_n = 1'b1;
    @(negedge e);
  endtask

  task automatic test_back_to_back();
    int di, ri;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] op;
      logic [20:0] a;
      logic [7:0] l, d;
      op = 2'($urandom);
      a = ($urandom_range(1) == 1) ? {13'($urandom), 8'($urandom_range(255, 250))} : 21'($urandom);
      l = 8'($urandom_range(12, 1));
      d = 8'($urandom);
      model(op, a, l, d);
      exec(op, a, l, d, 70, 0, -1, 600);
      di = bus_diff();
      ri = rsp_diff();
      vectors++; if (di !== -1) begin miscompares++; report_bus("b2b_bus", di); end
      vectors++; if (ri !== -1 || done_cnt !== 1) begin
        miscompares++; $display("FAIL b2b_rsp_done: rsp diff %0d done %0d exp -1/1", ri, done_cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_data = '0;
    rsp_ready = 1'b0; data_in = '0;
    test_reset();
    test_reg_wr();
    test_reg_rd();
    test_mem_fill();
    test_fill_wrap();
    test_dump();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
